// File: rtl/sim_multi_angle_if.sv
// rtl/sim_multi_angle_if.sv - channel configuration write bus for sim_multi_angle
// master drives the write strobe and fields, slave answers with cfg_ack.
interface sim_multi_angle_if #(
  parameter int AW = 12,
  parameter int SW = 8,
  parameter int CW = 2
);
  logic          cfg_wr;
  logic [CW-1:0] cfg_ch;
  logic [AW-1:0] cfg_start;
  logic [AW-1:0] cfg_width;
  logic [SW-1:0] cfg_step;
  logic [2:0]    cfg_rate;
  logic          cfg_motion;
  logic          cfg_dir;
  logic          cfg_ack;

  modport master (
    output cfg_wr, cfg_ch, cfg_start, cfg_width, cfg_step, cfg_rate, cfg_motion, cfg_dir,
    input  cfg_ack
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_start, cfg_width, cfg_step, cfg_rate, cfg_motion, cfg_dir,
    output cfg_ack
  );
endinterface

// File: rtl/sim_multi_angle.sv
// rtl/sim_multi_angle.sv - NCH-channel azimuth target gates with scan-synchronous motion
// SIM_ANGLE_REF_EN builds the static target_ref comparators; otherwise target_ref is 0.
module sim_multi_angle #(
  parameter int AW  = 12,
  parameter int NCH = 4,
  parameter int SW  = 8,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             resset,
  input  logic [AW-1:0]    bear,
  sim_multi_angle_if.slave cfg,
  output logic             north,
  output logic [NCH-1:0]   target_angle,
  output logic [NCH-1:0]   target_ref
);

  typedef struct packed {
    logic [AW-1:0] start;
    logic [AW-1:0] width;
    logic [SW-1:0] step;
    logic [2:0]    rate;
    logic          motion;
    logic          dir;
  } chan_cfg_t;

  chan_cfg_t      shadow   [NCH];
  chan_cfg_t      active   [NCH];
  logic [AW-1:0]  offset   [NCH];
  logic [6:0]     scan_cnt [NCH];
  logic [NCH-1:0] dirty;
  logic [AW-1:0]  bear_q;

  logic [AW-1:0]  back_dist;
  logic           nc;
  chan_cfg_t      wr_cfg;
  logic [AW-1:0]  vstart   [NCH];
  logic [AW-1:0]  step_ext [NCH];
  logic [NCH-1:0] ang_hit;
  logic [NCH-1:0] cnt_last;

  // Only a backward jump of at least half a revolution counts as north.
  assign back_dist = bear_q - bear;
  assign nc        = (bear < bear_q) && back_dist[AW-1];

  assign wr_cfg = '{start:  cfg.cfg_start,
                    width:  cfg.cfg_width,
                    step:   cfg.cfg_step,
                    rate:   cfg.cfg_rate,
                    motion: cfg.cfg_motion,
                    dir:    cfg.cfg_dir};

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      vstart[i]   = active[i].start + offset[i];
      step_ext[i] = AW'(active[i].step);
      ang_hit[i]  = (AW'(bear_q - vstart[i]) < active[i].width);
      cnt_last[i] = ({1'b0, scan_cnt[i]} == ((8'd1 << active[i].rate) - 8'd1));
    end
  end

  always_ff @(posedge clk or posedge resset) begin
    if (resset) begin
      bear_q       <= '0;
      north        <= 1'b0;
      cfg.cfg_ack  <= 1'b0;
      target_angle <= '0;
      dirty        <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow[i]   <= '0;
        active[i]   <= '0;
        offset[i]   <= '0;
        scan_cnt[i] <= '0;
      end
    end else begin
      bear_q      <= bear;
      north       <= nc;
      cfg.cfg_ack <= cfg.cfg_wr;
      for (int i = 0; i < NCH; i++) begin
        target_angle[i] <= ang_hit[i];
        if (nc) begin
          if (dirty[i]) begin
            active[i]   <= shadow[i];
            offset[i]   <= '0;
            scan_cnt[i] <= '0;
            dirty[i]    <= 1'b0;
          end else if (active[i].motion) begin
            if (cnt_last[i]) begin
              scan_cnt[i] <= '0;
              offset[i]   <= active[i].dir ? offset[i] + step_ext[i] : offset[i] - step_ext[i];
            end else begin
              scan_cnt[i] <= scan_cnt[i] + 7'd1;
            end
          end else begin
            offset[i] <= '0;
          end
        end
        // A write on the crossing cycle lands after the shadow->active copy above.
        if (cfg.cfg_wr && (cfg.cfg_ch == CW'(i))) begin
          shadow[i] <= wr_cfg;
          dirty[i]  <= 1'b1;
        end
      end
    end
  end

`ifdef SIM_ANGLE_REF_EN
  logic [NCH-1:0] ref_hit;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ref_hit[i] = (AW'(bear_q - active[i].start) < active[i].width);
    end
  end

  always_ff @(posedge clk or posedge resset) begin
    if (resset) begin
      target_ref <= '0;
    end else begin
      target_ref <= ref_hit;
    end
  end
`else
  assign target_ref = '0;
`endif

endmodule

// File: tb/tb_sim_multi_angle.sv
// tb/tb_sim_multi_angle.sv - directed scans plus randomized config against a scan-level model
`timescale 1ns/1ps
module tb_sim_multi_angle;
  localparam int AW  = 12;
  localparam int NCH = 4;
  localparam int SW  = 8;
  localparam int CW  = 2;
  localparam int REV = 4096;
`ifdef SIM_ANGLE_REF_EN
  localparam bit REF_ON = 1'b1;
`else
  localparam bit REF_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           resset;
  logic [AW-1:0]  bear;
  logic           north;
  logic [NCH-1:0] target_angle;
  logic [NCH-1:0] target_ref;

  sim_multi_angle_if #(.AW(AW), .SW(SW), .CW(CW)) cif ();

  sim_multi_angle #(.AW(AW), .NCH(NCH), .SW(SW), .CW(CW)) dut (
    .clk          (clk),
    .resset       (resset),
    .bear         (bear),
    .cfg          (cif),
    .north        (north),
    .target_angle (target_angle),
    .target_ref   (target_ref)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel programmed and live settings.
  int sh_st[NCH], sh_wd[NCH], sh_sp[NCH], sh_rt[NCH], sh_mo[NCH], sh_di[NCH];
  bit sh_pend[NCH];
  int ac_st[NCH], ac_wd[NCH], ac_sp[NCH], ac_rt[NCH], ac_mo[NCH], ac_di[NCH];
  int off[NCH], scans_since_move[NCH];
  int m_prev_bear, g_bear;
  logic [NCH-1:0] e_angle, e_ref;
  logic e_north, e_ack;

  // Directed scan observations.
  bit track_on = 1'b0;
  int scan_idx = 0, prev_g = 0;
  int last_rise[12][NCH];
  int hi_cnt[12][NCH];
  int ref_rise2[12];
  logic [NCH-1:0] prev_gate = '0;
  logic prev_ref2 = 1'b0;

  int bv, rev;
  int t_st[NCH] = '{100, 4080, 200, 2};
  int t_wd[NCH] = '{50, 40, 10, 4};
  int t_sp[NCH] = '{0, 0, 5, 3};
  int t_rt[NCH] = '{0, 0, 1, 0};
  int t_mo[NCH] = '{0, 0, 1, 1};
  int t_di[NCH] = '{0, 0, 1, 0};
  int exp2[6] = '{-1, 200, 200, 205, 205, 210};
  int exp3[6] = '{-1, 2, 4095, 4092, 4089, 4086};

  function automatic int wrapc(int x);
    return ((x % REV) + REV) % REV;
  endfunction

  function automatic bit in_sec(int b, int s, int w);
    return wrapc(b - s) < w;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      sh_st[i] = 0; sh_wd[i] = 0; sh_sp[i] = 0; sh_rt[i] = 0; sh_mo[i] = 0; sh_di[i] = 0;
      sh_pend[i] = 1'b0;
      ac_st[i] = 0; ac_wd[i] = 0; ac_sp[i] = 0; ac_rt[i] = 0; ac_mo[i] = 0; ac_di[i] = 0;
      off[i] = 0; scans_since_move[i] = 0;
    end
    m_prev_bear = 0; g_bear = 0;
    e_angle = '0; e_ref = '0; e_north = 1'b0; e_ack = 1'b0;
  endtask

  task automatic model_edge();
    int b;
    bit crossing;
    b = int'(bear);
    g_bear = m_prev_bear;
    for (int i = 0; i < NCH; i++) begin
      e_angle[i] = in_sec(m_prev_bear, ac_st[i] + off[i], ac_wd[i]);
      e_ref[i]   = REF_ON ? in_sec(m_prev_bear, ac_st[i], ac_wd[i]) : 1'b0;
    end
    crossing = (b < m_prev_bear) && ((m_prev_bear - b) >= REV / 2);
    e_north = crossing;
    e_ack   = cif.cfg_wr;
    if (crossing) begin
      for (int i = 0; i < NCH; i++) begin
        if (sh_pend[i]) begin
          ac_st[i] = sh_st[i]; ac_wd[i] = sh_wd[i]; ac_sp[i] = sh_sp[i];
          ac_rt[i] = sh_rt[i]; ac_mo[i] = sh_mo[i]; ac_di[i] = sh_di[i];
          off[i] = 0; scans_since_move[i] = 0; sh_pend[i] = 1'b0;
        end else if (ac_mo[i] != 0) begin
          if (scans_since_move[i] == (1 << ac_rt[i]) - 1) begin
            scans_since_move[i] = 0;
            off[i] = wrapc(off[i] + (ac_di[i] != 0 ? ac_sp[i] : -ac_sp[i]));
          end else begin
            scans_since_move[i]++;
          end
        end else begin
          off[i] = 0;
        end
      end
    end
    if (cif.cfg_wr && int'(cif.cfg_ch) < NCH) begin
      sh_st[cif.cfg_ch] = int'(cif.cfg_start);
      sh_wd[cif.cfg_ch] = int'(cif.cfg_width);
      sh_sp[cif.cfg_ch] = int'(cif.cfg_step);
      sh_rt[cif.cfg_ch] = int'(cif.cfg_rate);
      sh_mo[cif.cfg_ch] = int'(cif.cfg_motion);
      sh_di[cif.cfg_ch] = int'(cif.cfg_dir);
      sh_pend[cif.cfg_ch] = 1'b1;
    end
    m_prev_bear = b;
  endtask

  task automatic track();
    int s;
    if (g_bear == 0 && prev_g != 0) scan_idx++;
    prev_g = g_bear;
    s = scan_idx;
    if (s < 12) begin
      for (int i = 0; i < NCH; i++) begin
        if (target_angle[i]) hi_cnt[s][i]++;
        if (target_angle[i] && !prev_gate[i]) last_rise[s][i] = g_bear;
      end
      if (target_ref[2] && !prev_ref2) ref_rise2[s] = g_bear;
    end
    prev_gate = target_angle;
    prev_ref2 = target_ref[2];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("target_angle", 32'(target_angle), 32'(e_angle));
    chk("target_ref", 32'(target_ref), 32'(e_ref));
    chk("north", 32'(north), 32'(e_north));
    chk("cfg_ack", 32'(cif.cfg_ack), 32'(e_ack));
    if (track_on) track();
  endtask

  task automatic put_cfg(int ch, int st, int wd, int sp, int rt, int mo, int di);
    cif.cfg_wr     = 1'b1;
    cif.cfg_ch     = CW'(ch);
    cif.cfg_start  = AW'(st);
    cif.cfg_width  = AW'(wd);
    cif.cfg_step   = SW'(sp);
    cif.cfg_rate   = 3'(rt);
    cif.cfg_motion = 1'(mo);
    cif.cfg_dir    = 1'(di);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 12; s++) begin
      ref_rise2[s] = -1;
      for (int i = 0; i < NCH; i++) begin
        last_rise[s][i] = -1;
        hi_cnt[s][i] = 0;
      end
    end
    resset = 1'b1;
    bear = '0;
    put_cfg(0, 0, 0, 0, 0, 0, 0);
    cif.cfg_wr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_angle", 32'(target_angle), 0);
    chk("reset_ref", 32'(target_ref), 0);
    chk("reset_north", 32'(north), 0);
    chk("reset_ack", 32'(cif.cfg_ack), 0);
    resset = 1'b0;

    // Directed scans: table config in scan 0, write pair around the scan 6/7 crossing.
    bv = 0; rev = 0; track_on = 1'b1;
    for (int c = 0; c < 40000 && scan_idx < 9; c++) begin
      bv = (bv + 1) % REV;
      if (bv == 0) rev++;
      bear = AW'(bv);
      cif.cfg_wr = 1'b0;
      if (rev == 0 && bv >= 500 && bv < 500 + NCH)
        put_cfg(bv - 500, t_st[bv-500], t_wd[bv-500], t_sp[bv-500], t_rt[bv-500], t_mo[bv-500], t_di[bv-500]);
      if (rev == 6 && bv == 700) put_cfg(0, 1000, 30, 0, 0, 0, 0);
      if (rev == 7 && bv == 0)   put_cfg(0, 2000, 20, 0, 0, 0, 0);
      tick();
    end
    track_on = 1'b0;
    chk("scan_budget", 32'(scan_idx), 9);

    for (int i = 0; i < NCH; i++) chk("unconfigured_scan0_high", 32'(hi_cnt[0][i]), 0);
    for (int s = 1; s <= 5; s++) begin
      chk("ch0_static_rise", 32'(last_rise[s][0]), 100);
      chk("ch0_static_width", 32'(hi_cnt[s][0]), 50);
      chk("ch1_wrap_rise", 32'(last_rise[s][1]), 4080);
      chk("ch1_wrap_width", 32'(hi_cnt[s][1]), 40);
      chk("ch2_inward_rise", 32'(last_rise[s][2]), 32'(exp2[s]));
      chk("ch2_inward_width", 32'(hi_cnt[s][2]), 10);
      chk("ch3_outward_rise", 32'(last_rise[s][3]), 32'(exp3[s]));
      chk("ch3_outward_width", 32'(hi_cnt[s][3]), 4);
      chk("ch2_ref_rise", 32'(ref_rise2[s]), REF_ON ? 200 : 32'hFFFF_FFFF);
    end
    chk("ch0_old_shadow_rise", 32'(last_rise[7][0]), 1000);
    chk("ch0_old_shadow_width", 32'(hi_cnt[7][0]), 30);
    chk("ch0_new_cfg_rise", 32'(last_rise[8][0]), 2000);
    chk("ch0_new_cfg_width", 32'(hi_cnt[8][0]), 20);

    // Mid-scan asynchronous reset with a pending write that must be lost.
    while (bv != 2010) begin
      bv = (bv + 1) % REV;
      bear = AW'(bv);
      cif.cfg_wr = 1'b0;
      if (bv == 2005) put_cfg(1, 0, 4095, 0, 0, 0, 0);
      tick();
    end
    chk("ch0_gate_before_reset", 32'(target_angle[0]), 1);
    #2 resset = 1'b1;
    #1;
    chk("async_reset_angle", 32'(target_angle), 0);
    chk("async_reset_ref", 32'(target_ref), 0);
    chk("async_reset_north", 32'(north), 0);
    chk("async_reset_ack", 32'(cif.cfg_ack), 0);
    @(posedge clk);
    @(negedge clk);
    chk("held_reset_angle", 32'(target_angle), 0);
    resset = 1'b0;
    model_reset();
    for (int c = 0; c < 5000; c++) begin
      bv = (bv + 1) % REV;
      bear = AW'(bv);
      cif.cfg_wr = 1'b0;
      tick();
    end

    // Randomized configuration, crossing-cycle writes and small backward jitter.
    for (int c = 0; c < 14000; c++) begin
      if (bv > 100 && bv < 4000 && $urandom_range(0, 63) == 0)
        bv = bv - int'($urandom_range(1, 3));
      else
        bv = (bv + 1) % REV;
      bear = AW'(bv);
      cif.cfg_wr = 1'b0;
      if ((bv == 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 299) == 0) begin
        int wsel, wd;
        wsel = int'($urandom_range(0, 5));
        wd = (wsel == 0) ? 0 : (wsel == 1) ? 4095 : int'($urandom_range(1, 600));
        put_cfg(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, REV - 1)), wd,
                int'($urandom_range(0, 255)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      end
      tick();
    end
    cif.cfg_wr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
